// File: rtl/sa3d_ctrl_pkg.sv
// Shared types and constants for the SA3D layer sequencer.
package sa3d_ctrl_pkg;

  localparam int unsigned CFG_FW     = 16;
  localparam int unsigned NUM_FIELDS = 9;
  localparam int unsigned FIDX_W     = 4;

  localparam logic [FIDX_W-1:0] F_STRIDE   = 4'd0;
  localparam logic [FIDX_W-1:0] F_KERNEL   = 4'd1;
  localparam logic [FIDX_W-1:0] F_IN_SIZE  = 4'd2;
  localparam logic [FIDX_W-1:0] F_IN_CH    = 4'd3;
  localparam logic [FIDX_W-1:0] F_OUT_CH   = 4'd4;
  localparam logic [FIDX_W-1:0] F_OUT_SIZE = 4'd5;
  localparam logic [FIDX_W-1:0] F_WMAT_ROW = 4'd6;
  localparam logic [FIDX_W-1:0] F_OMAT_COL = 4'd7;
  localparam logic [FIDX_W-1:0] F_OMAT_ROW = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_START, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic [CFG_FW-1:0] stride;
    logic [CFG_FW-1:0] kernel;
    logic [CFG_FW-1:0] in_size;
    logic [CFG_FW-1:0] in_ch;
    logic [CFG_FW-1:0] out_ch;
    logic [CFG_FW-1:0] out_size;
    logic [CFG_FW-1:0] wmat_row;
    logic [CFG_FW-1:0] omat_col;
    logic [CFG_FW-1:0] omat_row;
  } layer_cfg_t;

  // Return cfg with one field replaced; unknown field indices leave it unchanged.
  function automatic layer_cfg_t set_field(input layer_cfg_t cfg,
                                           input logic [FIDX_W-1:0] fidx,
                                           input logic [CFG_FW-1:0] val);
    layer_cfg_t r;
    r = cfg;
    case (fidx)
      F_STRIDE:   r.stride   = val;
      F_KERNEL:   r.kernel   = val;
      F_IN_SIZE:  r.in_size  = val;
      F_IN_CH:    r.in_ch    = val;
      F_OUT_CH:   r.out_ch   = val;
      F_OUT_SIZE: r.out_size = val;
      F_WMAT_ROW: r.wmat_row = val;
      F_OMAT_COL: r.omat_col = val;
      F_OMAT_ROW: r.omat_row = val;
      default:    r = cfg;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sa3d_layer_sequencer_if.sv
// Host/SA3D-facing signal bundle of the layer sequencer.
// master = host + SA3D side, slave = sequencer.
interface sa3d_layer_sequencer_if #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned FW         = 16,
  parameter int unsigned TW         = 32
);
  localparam int unsigned LW = $clog2(MAX_LAYERS);

  logic          cfg_we;
  logic [LW+3:0] cfg_addr;
  logic [FW-1:0] cfg_wdata;
  logic [LW:0]   num_layers;
  logic [TW-1:0] timeout_limit;
  logic          run_start;
  logic          abort;

  logic          sa_start;
  logic [FW-1:0] sa_stride;
  logic [FW-1:0] sa_kernel;
  logic [FW-1:0] sa_in_size;
  logic [FW-1:0] sa_in_ch;
  logic [FW-1:0] sa_out_ch;
  logic [FW-1:0] sa_out_size;
  logic [FW-1:0] sa_wmat_row;
  logic [FW-1:0] sa_omat_col;
  logic [FW-1:0] sa_omat_row;

  logic          sa_out_valid;
  logic          sa_out_ready;
  logic          sa_out_last;

  logic          busy;
  logic          done;
  logic          err_timeout;
  logic [LW-1:0] layer_idx;
  logic [TW-1:0] beat_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, num_layers, timeout_limit, run_start, abort,
    output sa_out_valid, sa_out_ready, sa_out_last,
    input  sa_start, sa_stride, sa_kernel, sa_in_size, sa_in_ch, sa_out_ch,
    input  sa_out_size, sa_wmat_row, sa_omat_col, sa_omat_row,
    input  busy, done, err_timeout, layer_idx, beat_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, num_layers, timeout_limit, run_start, abort,
    input  sa_out_valid, sa_out_ready, sa_out_last,
    output sa_start, sa_stride, sa_kernel, sa_in_size, sa_in_ch, sa_out_ch,
    output sa_out_size, sa_wmat_row, sa_omat_col, sa_omat_row,
    output busy, done, err_timeout, layer_idx, beat_cnt
  );

endinterface

// File: rtl/sa3d_desc_ram.sv
// Layer descriptor register file: field-granular synchronous write, combinational read.
module sa3d_desc_ram
  import sa3d_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned LW         = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [LW-1:0]     i_waddr,
  input  logic [FIDX_W-1:0] i_field,
  input  logic [CFG_FW-1:0] i_wdata,
  input  logic [LW-1:0]     i_raddr,
  output layer_cfg_t        o_rdata_c
);

  layer_cfg_t r_mem [MAX_LAYERS];

  // Field write; indices past the last field are dropped.
  always_ff @(posedge clk) begin
    if (i_we && (i_field < FIDX_W'(NUM_FIELDS))) begin
      r_mem[i_waddr] <= set_field(r_mem[i_waddr], i_field, i_wdata);
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/sa3d_layer_sequencer.sv
// Walks the programmed layer list through SA3D: load config, pulse start,
// count output beats until last, then advance or finish.
module sa3d_layer_sequencer
  import sa3d_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned FW         = CFG_FW,
  parameter int unsigned TW         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sa3d_layer_sequencer_if.slave  bus
);

  localparam int unsigned LW = $clog2(MAX_LAYERS);
  localparam int unsigned NW = LW + 1;

  state_t       r_state, w_state_nxt;
  logic [LW-1:0] r_layer_idx, w_layer_nxt;
  logic [NW-1:0] r_num_layers, w_num_nxt;
  logic [TW-1:0] r_limit, w_limit_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt, w_to_inc;
  logic [TW-1:0] r_beat_cnt, w_beat_nxt, w_beat_inc;
  logic          r_err, w_err_nxt;
  layer_cfg_t    r_cfg, w_cfg_nxt, w_rd_cfg;
  logic          r_sa_start, r_done, r_busy;

  logic          w_hs, w_we;
  logic [NW-1:0] w_num_clamped, w_idx_plus1;
  logic [FW-1:0] w_cfg_wdata;

  assign w_hs          = bus.sa_out_valid && bus.sa_out_ready;
  assign w_we          = bus.cfg_we && !r_busy;
  assign w_cfg_wdata   = bus.cfg_wdata;
  assign w_num_clamped = (bus.num_layers > NW'(MAX_LAYERS)) ? NW'(MAX_LAYERS) : bus.num_layers;
  assign w_idx_plus1   = NW'(r_layer_idx) + NW'(1);
  assign w_to_inc      = (r_to_cnt == '1)   ? r_to_cnt   : r_to_cnt + TW'(1);
  assign w_beat_inc    = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + TW'(1);

  sa3d_desc_ram #(
    .MAX_LAYERS (MAX_LAYERS)
  ) u_desc_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (bus.cfg_addr[LW+3:4]),
    .i_field   (bus.cfg_addr[3:0]),
    .i_wdata   (CFG_FW'(w_cfg_wdata)),
    .i_raddr   (r_layer_idx),
    .o_rdata_c (w_rd_cfg)
  );

  // State and datapath registers; sa_start/done/busy are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_layer_idx  <= '0;
      r_num_layers <= '0;
      r_limit      <= '0;
      r_to_cnt     <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_cfg        <= '0;
      r_sa_start   <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_layer_idx  <= w_layer_nxt;
      r_num_layers <= w_num_nxt;
      r_limit      <= w_limit_nxt;
      r_to_cnt     <= w_to_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_err        <= w_err_nxt;
      r_cfg        <= w_cfg_nxt;
      r_sa_start   <= (w_state_nxt == S_START);
      r_done       <= (w_state_nxt == S_DONE);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state and register updates; abort freezes everything and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer_idx;
    w_num_nxt   = r_num_layers;
    w_limit_nxt = r_limit;
    w_to_nxt    = r_to_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_err_nxt   = r_err;
    w_cfg_nxt   = r_cfg;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.run_start) begin
            if (bus.num_layers == '0) begin
              w_state_nxt = S_DONE;
            end else begin
              w_num_nxt   = w_num_clamped;
              w_limit_nxt = bus.timeout_limit;
              w_layer_nxt = '0;
              w_err_nxt   = 1'b0;
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w_cfg_nxt   = w_rd_cfg;
          w_beat_nxt  = '0;
          w_to_nxt    = '0;
          w_state_nxt = S_SETTLE;
        end
        S_SETTLE: w_state_nxt = S_START;
        S_START:  w_state_nxt = S_RUN;
        S_RUN: begin
          if (w_hs) begin
            w_beat_nxt = w_beat_inc;
            w_to_nxt   = '0;
            if (bus.sa_out_last) begin
              w_state_nxt = S_NEXT;
            end
          end else begin
            w_to_nxt = w_to_inc;
            if ((r_limit != '0) && (w_to_inc >= r_limit)) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_ERR;
            end
          end
        end
        S_NEXT: begin
          if (w_idx_plus1 == r_num_layers) begin
            w_state_nxt = S_DONE;
          end else begin
            w_layer_nxt = r_layer_idx + LW'(1);
            w_state_nxt = S_LOAD;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.sa_start    = r_sa_start;
  assign bus.sa_stride   = FW'(r_cfg.stride);
  assign bus.sa_kernel   = FW'(r_cfg.kernel);
  assign bus.sa_in_size  = FW'(r_cfg.in_size);
  assign bus.sa_in_ch    = FW'(r_cfg.in_ch);
  assign bus.sa_out_ch   = FW'(r_cfg.out_ch);
  assign bus.sa_out_size = FW'(r_cfg.out_size);
  assign bus.sa_wmat_row = FW'(r_cfg.wmat_row);
  assign bus.sa_omat_col = FW'(r_cfg.omat_col);
  assign bus.sa_omat_row = FW'(r_cfg.omat_row);
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err_timeout = r_err;
  assign bus.layer_idx   = r_layer_idx;
  assign bus.beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_sa3d_layer_sequencer.sv
// Directed, table-driven bench for the SA3D layer sequencer.
module tb_sa3d_layer_sequencer;

  localparam int unsigned ML  = 8;
  localparam int unsigned FWT = 16;
  localparam int unsigned TWT = 32;

  typedef logic [8:0][15:0] fields_t;
  typedef logic [7:0][8:0][15:0] layers_t;

  typedef struct {
    fields_t     cfg;
    int          beats;
    logic [31:0] exp_beat;
    logic [15:0] exp_omat_row;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa3d_layer_sequencer_if #(.MAX_LAYERS(ML), .FW(FWT), .TW(TWT)) bus ();

  sa3d_layer_sequencer #(.MAX_LAYERS(ML), .FW(FWT), .TW(TWT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Count sa_start pulses mid-cycle.
  always @(negedge clk) if (!rst && bus.sa_start) start_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fields_t mk(input int s, input int k, input int is, input int ic,
                                 input int oc, input int os, input int wr, input int ocol,
                                 input int orow);
    fields_t f;
    f[0] = 16'(s);  f[1] = 16'(k);  f[2] = 16'(is);
    f[3] = 16'(ic); f[4] = 16'(oc); f[5] = 16'(os);
    f[6] = 16'(wr); f[7] = 16'(ocol); f[8] = 16'(orow);
    return f;
  endfunction

  function automatic fields_t sa_now();
    fields_t f;
    f[0] = bus.sa_stride;   f[1] = bus.sa_kernel;   f[2] = bus.sa_in_size;
    f[3] = bus.sa_in_ch;    f[4] = bus.sa_out_ch;   f[5] = bus.sa_out_size;
    f[6] = bus.sa_wmat_row; f[7] = bus.sa_omat_col; f[8] = bus.sa_omat_row;
    return f;
  endfunction

  task automatic write_field(input int layer, input int field, input logic [15:0] v);
    bus.cfg_addr  = {3'(layer), 4'(field)};
    bus.cfg_wdata = v;
    bus.cfg_we    = 1'b1;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic write_layer(input int layer, input fields_t f);
    for (int i = 0; i < 9; i++) write_field(layer, i, f[i]);
  endtask

  // Pulse run_start in the current cycle T; returns in cycle T+1.
  task automatic start_run(input int n, input int limit);
    bus.num_layers    = 4'(n);
    bus.timeout_limit = 32'(limit);
    bus.run_start     = 1'b1;
    step();
    bus.run_start     = 1'b0;
  endtask

  // Drive n back-to-back handshakes; returns one cycle after the last.
  task automatic beats(input int n, input bit with_last);
    for (int b = 1; b <= n; b++) begin
      bus.sa_out_valid = 1'b1;
      bus.sa_out_ready = 1'b1;
      bus.sa_out_last  = with_last && (b == n);
      step();
    end
    bus.sa_out_valid = 1'b0;
    bus.sa_out_ready = 1'b0;
    bus.sa_out_last  = 1'b0;
  endtask

  // Full run with cycle-exact checks of start, config, index, beats and done.
  task automatic run_layers(input string tag, input int n_req, input int n_exp,
                            input int nb, input layers_t exp);
    int s0;
    s0 = start_cnt;
    start_run(n_req, 0);
    check($sformatf("%s busy@T+1", tag), 144'(bus.busy), 144'(1));
    step();
    check($sformatf("%s cfg@T+2", tag), 144'(sa_now()), 144'(exp[0]));
    check($sformatf("%s no_start@T+2", tag), 144'(bus.sa_start), 144'(0));
    step();
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("%s l%0d sa_start", tag, i), 144'(bus.sa_start), 144'(1));
      check($sformatf("%s l%0d cfg", tag, i), 144'(sa_now()), 144'(exp[i]));
      check($sformatf("%s l%0d layer_idx", tag, i), 144'(bus.layer_idx), 144'(i));
      step();
      beats(nb, 1'b1);
      check($sformatf("%s l%0d beat_cnt", tag, i), 144'(bus.beat_cnt), 144'(nb));
      if (i < n_exp - 1) begin
        step();
        step();
        check($sformatf("%s l%0d no_start@L+3", tag, i), 144'(bus.sa_start), 144'(0));
        step();
      end else begin
        step();
        check($sformatf("%s done@L+2", tag), 144'(bus.done), 144'(1));
        step();
        check($sformatf("%s busy@L+3", tag), 144'(bus.busy), 144'(0));
        check($sformatf("%s done@L+3", tag), 144'(bus.done), 144'(0));
      end
    end
    check($sformatf("%s start_count", tag), 144'(start_cnt - s0), 144'(n_exp));
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s sa_start", tag), 144'(bus.sa_start), 144'(0));
    check($sformatf("%s sa_cfg", tag), 144'(sa_now()), 144'(0));
    check($sformatf("%s busy", tag), 144'(bus.busy), 144'(0));
    check($sformatf("%s done", tag), 144'(bus.done), 144'(0));
    check($sformatf("%s err", tag), 144'(bus.err_timeout), 144'(0));
    check($sformatf("%s layer_idx", tag), 144'(bus.layer_idx), 144'(0));
    check($sformatf("%s beat_cnt", tag), 144'(bus.beat_cnt), 144'(0));
  endtask

  vec_t    vecs [3];
  layers_t e;
  layers_t clamp_e;
  fields_t p0;
  int      s0;

  initial begin
    vecs[0] = '{cfg: mk(1, 3, 224, 8, 128, 222, 72, 128, 49284), beats: 10,
                exp_beat: 32'd10, exp_omat_row: 16'd49284};
    vecs[1] = '{cfg: mk(2, 5, 56, 64, 32, 26, 1600, 32, 676), beats: 1,
                exp_beat: 32'd1, exp_omat_row: 16'd676};
    vecs[2] = '{cfg: mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                        16'hFFFF, 16'hFFFF, 16'hFFFF), beats: 3,
                exp_beat: 32'd3, exp_omat_row: 16'hFFFF};
    p0 = vecs[0].cfg;

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.num_layers = '0; bus.timeout_limit = '0;
    bus.run_start = 1'b0; bus.abort = 1'b0;
    bus.sa_out_valid = 1'b0; bus.sa_out_ready = 1'b0; bus.sa_out_last = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Single-layer runs from the vector table.
    for (int v = 0; v < 3; v++) begin
      write_layer(0, vecs[v].cfg);
      e = '0;
      e[0] = vecs[v].cfg;
      run_layers($sformatf("vec%0d", v), 1, 1, vecs[v].beats, e);
      check($sformatf("vec%0d beat_cnt_hold", v), 144'(bus.beat_cnt), 144'(vecs[v].exp_beat));
      check($sformatf("vec%0d omat_row", v), 144'(bus.sa_omat_row), 144'(vecs[v].exp_omat_row));
    end

    // Three layers with kernels 3, 5, 7.
    e = '0;
    for (int i = 0; i < 3; i++) begin
      e[i] = mk(1, 3 + 2 * i, 32, 4, 16, 30 - 2 * i, 36, 16, 900);
      write_layer(i, e[i]);
    end
    run_layers("multi", 3, 3, 2, e);

    // Timeout after 100 idle RUN cycles, abort, then a new run clears the flag.
    write_layer(0, p0);
    start_run(1, 100);
    step();
    step();
    step();
    for (int k = 0; k < 99; k++) step();
    check("timeout err@R+99", 144'(bus.err_timeout), 144'(0));
    step();
    check("timeout err@R+100", 144'(bus.err_timeout), 144'(1));
    check("timeout busy@R+100", 144'(bus.busy), 144'(1));
    for (int k = 0; k < 5; k++) step();
    check("err busy held", 144'(bus.busy), 144'(1));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort busy", 144'(bus.busy), 144'(0));
    check("abort err sticky", 144'(bus.err_timeout), 144'(1));
    check("abort no done", 144'(bus.done), 144'(0));
    start_run(1, 0);
    check("rerun clears err", 144'(bus.err_timeout), 144'(0));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort2 busy", 144'(bus.busy), 144'(0));

    // Writes, stray last and run_start while busy are all ignored.
    s0 = start_cnt;
    start_run(1, 0);
    bus.cfg_addr = {3'd0, 4'd1}; bus.cfg_wdata = 16'd99; bus.cfg_we = 1'b1;
    bus.sa_out_valid = 1'b1; bus.sa_out_ready = 1'b1; bus.sa_out_last = 1'b1;
    bus.run_start = 1'b1; bus.num_layers = 4'd2;
    step();
    bus.cfg_we = 1'b0; bus.run_start = 1'b0;
    step();
    check("busy-ign sa_start@T+3", 144'(bus.sa_start), 144'(1));
    check("busy-ign kernel", 144'(bus.sa_kernel), 144'(3));
    bus.sa_out_valid = 1'b0; bus.sa_out_ready = 1'b0; bus.sa_out_last = 1'b0;
    step();
    check("busy-ign beat_cnt", 144'(bus.beat_cnt), 144'(0));
    bus.run_start = 1'b1;
    beats(1, 1'b0);
    bus.run_start = 1'b0;
    beats(2, 1'b1);
    check("busy-ign beats", 144'(bus.beat_cnt), 144'(3));
    step();
    check("busy-ign done", 144'(bus.done), 144'(1));
    for (int k = 0; k < 4; k++) step();
    check("busy-ign idle", 144'(bus.busy), 144'(0));
    check("busy-ign one start", 144'(start_cnt - s0), 144'(1));
    e = '0;
    e[0] = p0;
    run_layers("reread", 1, 1, 1, e);

    // num_layers = 0: immediate DONE, no start.
    s0 = start_cnt;
    start_run(0, 0);
    check("zero done", 144'(bus.done), 144'(1));
    step();
    check("zero done clr", 144'(bus.done), 144'(0));
    check("zero busy", 144'(bus.busy), 144'(0));
    check("zero no start", 144'(start_cnt - s0), 144'(0));

    // num_layers = 15 clamps to 8 layers.
    clamp_e = '0;
    for (int i = 0; i < 8; i++) begin
      clamp_e[i] = mk(1, 10 + i, 20 + i, 2, 4, 18 + i, 18, 4, 100 + i);
      write_layer(i, clamp_e[i]);
    end
    run_layers("clamp", 15, 8, 1, clamp_e);

    // Reset during RUN of layer 1, then a run restarts from layer 0.
    start_run(2, 0);
    step();
    step();
    step();
    beats(1, 1'b1);
    for (int k = 0; k < 4; k++) step();
    check("rst-pre layer_idx", 144'(bus.layer_idx), 144'(1));
    beats(2, 1'b0);
    check("rst-pre beat_cnt", 144'(bus.beat_cnt), 144'(2));
    rst = 1'b1;
    step();
    check_reset_values("midrun_rst");
    rst = 1'b0;
    e = '0;
    e[0] = clamp_e[0];
    run_layers("after_rst", 1, 1, 1, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
